// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the execute unit: ALU select codes and FSM states.
// Also holds small decode helpers used by the top.
package alu_muldiv_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_LUI    = 5'd10,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic sel_legal(input logic [4:0] sel);
      return (sel <= 5'd10) || ((sel >= 5'd16) && (sel <= 5'd23));
   endfunction

   // 16..23: the whole RV32M group
   function automatic logic sel_is_muldiv(input logic [4:0] sel);
      return sel[4:3] == 2'b10;
   endfunction

   // 20..23: DIV, DIVU, REM, REMU
   function automatic logic sel_is_div(input logic [4:0] sel);
      return sel[4:2] == 3'b101;
   endfunction

endpackage

// File: rtl/alu_muldiv_muldiv_iter.sv
// Iterative multiply/divide datapath: one product or quotient bit per cycle
// over operand magnitudes, with the sign fix applied on the final step.
module muldiv_iter
   import alu_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_is_div,
   input  logic            i_sgn1,
   input  logic            i_sgn2,
   input  logic            i_sel_hi,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN);

   logic                  r_busy;
   logic [CW-1:0]         r_cnt;
   logic [2*XLEN-1:0]     r_acc;
   logic [XLEN-1:0]       r_opd;
   logic                  r_is_div;
   logic                  r_sel_hi;
   logic                  r_neg_q;
   logic                  r_neg_r;

   logic                  w_neg1, w_neg2;
   logic [XLEN-1:0]       w_mag1, w_mag2;
   logic [XLEN-1:0]       w_hi, w_lo;
   logic [XLEN:0]         w_sum, w_rsh, w_diff;
   logic [2*XLEN-1:0]     w_acc_nxt, w_prod;
   logic [XLEN-1:0]       w_q, w_r;

   assign w_neg1 = i_sgn1 & i_op1[XLEN-1];
   assign w_neg2 = i_sgn2 & i_op2[XLEN-1];
   assign w_mag1 = w_neg1 ? -i_op1 : i_op1;
   assign w_mag2 = w_neg2 ? -i_op2 : i_op2;

   assign w_hi = r_acc[2*XLEN-1:XLEN];
   assign w_lo = r_acc[XLEN-1:0];

   // Multiply: hi accumulates, lo shifts out multiplier bits LSB first.
   // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
   always_comb begin
      w_sum  = {1'b0, w_hi} + {1'b0, r_opd};
      w_rsh  = {w_hi, w_lo[XLEN-1]};
      w_diff = w_rsh - {1'b0, r_opd};
      if (r_is_div) begin
         if (!w_diff[XLEN]) begin
            w_acc_nxt = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
         end else begin
            w_acc_nxt = {w_rsh[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
         end
      end else if (w_lo[0]) begin
         w_acc_nxt = {w_sum, w_lo[XLEN-1:1]};
      end else begin
         w_acc_nxt = {1'b0, w_hi, w_lo[XLEN-1:1]};
      end
   end

   // Result is taken from the step being computed so the top can register it
   // on the same edge the counter expires.
   assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
   assign w_q    = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
   assign w_r    = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

   always_comb begin
      if (r_is_div) begin
         o_result = r_sel_hi ? w_r : w_q;
      end else begin
         o_result = r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
      end
   end

   assign o_done = r_busy && (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= CW'(XLEN-1);
      end else if (r_busy) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_start) begin
         r_is_div <= i_is_div;
         r_sel_hi <= i_sel_hi;
         r_neg_q  <= w_neg1 ^ w_neg2;
         r_neg_r  <= w_neg1;
         r_opd    <= i_is_div ? w_mag2 : w_mag1;
         r_acc    <= {{XLEN{1'b0}}, (i_is_div ? w_mag1 : w_mag2)};
      end else if (r_busy) begin
         r_acc <= w_acc_nxt;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle execute unit: single-cycle base ALU ops plus iterative RV32M
// multiply/divide behind a valid/ready handshake on both sides.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            I_clk,
   input  logic            I_rst,
   input  logic            I_valid,
   output logic            O_ready,
   input  logic [4:0]      I_alusel,
   input  logic [XLEN-1:0] I_data1,
   input  logic [XLEN-1:0] I_data2,
   output logic            O_valid,
   input  logic            I_ready,
   output logic [XLEN-1:0] O_data,
   output logic            O_illegalflag,
   output logic            O_busy
);

   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

   state_e          r_state;

   logic            w_accept;
   logic            w_legal, w_is_md, w_is_div;
   logic            w_div_zero, w_div_ovf, w_special;
   logic            w_start, w_done;
   logic            w_sgn1, w_sgn2, w_sel_hi;
   logic [XLEN-1:0] w_base, w_special_val, w_iter_res;

   function automatic logic [XLEN-1:0] base_op(input logic [4:0]      sel,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      logic [SHW-1:0]         sh;
      logic [XLEN-1:0]        r;
      sa = a;
      sb = b;
      sh = b[SHW-1:0];
      case (sel)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_SLL:  r = a << sh;
         ALU_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
         ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  r = a ^ b;
         ALU_SRL:  r = a >> sh;
         ALU_SRA:  r = sa >>> sh;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_LUI:  r = b;
         default:  r = '0;
      endcase
      return r;
   endfunction

   assign w_accept = (r_state == ST_IDLE) && I_valid;
   assign w_legal  = sel_legal(I_alusel);
   assign w_is_md  = sel_is_muldiv(I_alusel);
   assign w_is_div = sel_is_div(I_alusel);
   assign w_base   = base_op(I_alusel, I_data1, I_data2);

   // DIV/REM (even codes) are signed; the odd codes are the unsigned forms.
   assign w_div_zero    = (I_data2 == '0);
   assign w_div_ovf     = !I_alusel[0] && (I_data1 == MINV) && (I_data2 == '1);
   assign w_special     = w_is_div && (w_div_zero || w_div_ovf);
   assign w_special_val = I_alusel[1] ? (w_div_zero ? I_data1 : '0)
                                      : (w_div_zero ? '1 : MINV);

   assign w_sgn1   = w_is_div ? !I_alusel[0]
                              : ((I_alusel == ALU_MULH) || (I_alusel == ALU_MULHSU));
   assign w_sgn2   = w_is_div ? !I_alusel[0] : (I_alusel == ALU_MULH);
   assign w_sel_hi = w_is_div ? I_alusel[1] : (I_alusel[1:0] != 2'b00);
   assign w_start  = w_accept && w_legal && w_is_md && !w_special;

   muldiv_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .i_clk    (I_clk),
      .i_rst    (I_rst),
      .i_start  (w_start),
      .i_is_div (w_is_div),
      .i_sgn1   (w_sgn1),
      .i_sgn2   (w_sgn2),
      .i_sel_hi (w_sel_hi),
      .i_op1    (I_data1),
      .i_op2    (I_data2),
      .o_done   (w_done),
      .o_result (w_iter_res)
   );

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state       <= ST_IDLE;
         O_ready       <= 1'b1;
         O_valid       <= 1'b0;
         O_busy        <= 1'b0;
         O_data        <= '0;
         O_illegalflag <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  O_ready <= 1'b0;
                  if (!w_legal) begin
                     O_data        <= '0;
                     O_illegalflag <= 1'b1;
                     O_valid       <= 1'b1;
                     r_state       <= ST_DONE;
                  end else if (w_special) begin
                     O_data  <= w_special_val;
                     O_valid <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (w_is_md) begin
                     O_busy  <= 1'b1;
                     r_state <= w_is_div ? ST_DIV : ST_MUL;
                  end else begin
                     O_data  <= w_base;
                     O_valid <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               if (w_done) begin
                  O_data  <= w_iter_res;
                  O_busy  <= 1'b0;
                  O_valid <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (I_ready) begin
                  O_valid       <= 1'b0;
                  O_illegalflag <= 1'b0;
                  O_ready       <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (XLEN=32): a 64-bit arithmetic reference model
// plus a per-cycle compare process covering handshake, busy, latency and data.
module tb_alu_muldiv;

   localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3;
   localparam logic [4:0] SLTU = 5'd4, XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7;
   localparam logic [4:0] OR = 5'd8,   AND = 5'd9,  LUI = 5'd10;
   localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
   localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

   logic        clk = 1'b0;
   logic        I_rst, I_valid, I_ready;
   logic [4:0]  I_alusel;
   logic [31:0] I_data1, I_data2;
   logic        O_ready, O_valid, O_illegalflag, O_busy;
   logic [31:0] O_data;

   alu_muldiv #(.XLEN(32)) dut (
      .I_clk         (clk),
      .I_rst         (I_rst),
      .I_valid       (I_valid),
      .O_ready       (O_ready),
      .I_alusel      (I_alusel),
      .I_data1       (I_data1),
      .I_data2       (I_data2),
      .O_valid       (O_valid),
      .I_ready       (I_ready),
      .O_data        (O_data),
      .O_illegalflag (O_illegalflag),
      .O_busy        (O_busy)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   bit          pending = 1'b0;
   bit          exp_lng = 1'b0;
   bit          exp_ill = 1'b0;
   logic [31:0] exp_data = '0;
   logic [31:0] exp_lit = '0;
   int          exp_vcyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b at cyc=%0d", nm, got, exp, cyc);
      end
   endtask

   // Reference: plain 64-bit arithmetic with RV32M corner-case rules.
   function automatic void model(input logic [4:0] sel, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] d,
                                 output bit ill, output bit lng);
      longint sa, sb, ua, ub, p;
      logic [4:0] sh;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      sh  = b[4:0];
      d   = '0;
      ill = 1'b0;
      lng = 1'b0;
      p   = 0;
      case (sel)
         ADD:    d = a + b;
         SUB:    d = a - b;
         SLL:    d = a << sh;
         SLT:    d = (sa < sb) ? 32'd1 : 32'd0;
         SLTU:   d = (ua < ub) ? 32'd1 : 32'd0;
         XOR:    d = a ^ b;
         SRL:    d = a >> sh;
         SRA:    d = 32'($signed(a) >>> sh);
         OR:     d = a | b;
         AND:    d = a & b;
         LUI:    d = b;
         MUL:    begin p = sa * sb; d = p[31:0];  lng = 1'b1; end
         MULH:   begin p = sa * sb; d = p[63:32]; lng = 1'b1; end
         MULHSU: begin p = sa * ub; d = p[63:32]; lng = 1'b1; end
         MULHU:  begin p = ua * ub; d = p[63:32]; lng = 1'b1; end
         DIV: begin
            if (b == 0) d = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) d = 32'h80000000;
            else begin p = sa / sb; d = p[31:0]; lng = 1'b1; end
         end
         DIVU: begin
            if (b == 0) d = 32'hFFFFFFFF;
            else begin p = ua / ub; d = p[31:0]; lng = 1'b1; end
         end
         REM: begin
            if (b == 0) d = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) d = 32'd0;
            else begin p = sa % sb; d = p[31:0]; lng = 1'b1; end
         end
         REMU: begin
            if (b == 0) d = a;
            else begin p = ua % ub; d = p[31:0]; lng = 1'b1; end
         end
         default: ill = 1'b1;
      endcase
   endfunction

   // Per-cycle compare against the expectation set up by the driver.
   always @(negedge clk) begin
      if (chk_en) begin
         if (pending) begin
            chk1("cmp_valid", O_valid, (cyc >= exp_vcyc));
            chk1("cmp_busy", O_busy, (exp_lng && (cyc < exp_vcyc)));
            chk1("cmp_ready", O_ready, 1'b0);
            if (O_valid) begin
               chk("cmp_data", O_data, exp_data);
               chk1("cmp_ill", O_illegalflag, exp_ill);
            end
         end else begin
            chk1("idle_ready", O_ready, 1'b1);
            chk1("idle_valid", O_valid, 1'b0);
            chk1("idle_busy", O_busy, 1'b0);
         end
      end
   end

   task automatic start_op(input logic [4:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] lit, input string nm);
      logic [31:0] md;
      bit mi, ml;
      int acc;
      model(sel, a, b, md, mi, ml);
      chk({nm, "_model"}, md, lit);
      @(negedge clk);
      acc      = cyc;
      I_valid  = 1'b1;
      I_alusel = sel;
      I_data1  = a;
      I_data2  = b;
      @(posedge clk);
      #1;
      I_valid  = 1'b0;
      I_alusel = 5'($urandom);
      I_data1  = $urandom;
      I_data2  = $urandom;
      exp_data = md;
      exp_lit  = lit;
      exp_ill  = mi;
      exp_lng  = ml;
      exp_vcyc = acc + (ml ? 33 : 1);
      pending  = 1'b1;
   endtask

   task automatic finish_op(input int hold, input bit noise, input string nm);
      int k = 0;
      if (noise) begin
         I_valid  = 1'b1;
         I_alusel = ADD;
         I_data1  = 32'h11111111;
         I_data2  = 32'h22222222;
      end
      while (!O_valid && k < 60) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk1({nm, "_seen"}, O_valid, 1'b1);
      chk({nm, "_lit"}, O_data, exp_lit);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      I_ready = 1'b1;
      @(posedge clk);
      #1;
      I_ready = 1'b0;
      I_valid = 1'b0;
      pending = 1'b0;
   endtask

   task automatic op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input string nm);
      start_op(sel, a, b, lit, nm);
      finish_op(0, 1'b0, nm);
   endtask

   initial begin
      I_rst    = 1'b1;
      I_valid  = 1'b1;
      I_ready  = 1'b0;
      I_alusel = ADD;
      I_data1  = 32'd1;
      I_data2  = 32'd2;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_ready", O_ready, 1'b1);
      chk1("rst_valid", O_valid, 1'b0);
      chk("rst_data", O_data, 32'd0);
      chk1("rst_busy", O_busy, 1'b0);
      chk1("rst_ill", O_illegalflag, 1'b0);
      @(negedge clk);
      I_rst   = 1'b0;
      I_valid = 1'b0;
      chk_en  = 1'b1;
      repeat (2) @(posedge clk);

      op(ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, "add_wrap");
      op(SRA,    32'h80000000, 32'h00000024, 32'hF8000000, "sra");
      op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh");
      op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
      op(DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div_neg");
      op(REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "rem_neg");
      op(DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, "divu_zero");
      op(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
      op(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
      op(REM,    32'h00000005, 32'h00000000, 32'h00000005, "rem_zero");
      op(SUB,    32'h00000000, 32'h00000001, 32'hFFFFFFFF, "sub");
      op(SLL,    32'h00000001, 32'h0000001F, 32'h80000000, "sll");
      op(SRL,    32'h80000000, 32'h00000021, 32'h40000000, "srl");
      op(SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt");
      op(SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu");
      op(XOR,    32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, "xor");
      op(OR,     32'h000000F0, 32'h0000000F, 32'h000000FF, "or");
      op(AND,    32'h0000F0F0, 32'h0000FF00, 32'h0000F000, "and");
      op(LUI,    32'h12345678, 32'hABCDE000, 32'hABCDE000, "lui");
      op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
      op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
      op(DIV,    32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, "div_negdiv");
      op(REM,    32'h00000064, 32'hFFFFFFF9, 32'h00000002, "rem_negdiv");
      op(DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, "divu");
      op(REMU,   32'h00000064, 32'h00000007, 32'h00000002, "remu");
      op(DIV,    32'h80000000, 32'h00000001, 32'h80000000, "div_min");
      op(DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, "divu_max");
      op(5'd31,  32'h00000001, 32'h00000002, 32'h00000000, "illegal31");

      // Backpressure with a competing request held on I_valid.
      start_op(MUL, 32'h12345678, 32'h00000009, 32'hA3D70A38, "mul_bp");
      finish_op(5, 1'b1, "mul_bp");
      start_op(5'd13, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, "illegal13");
      finish_op(5, 1'b0, "illegal13");

      // Abort a divide partway through its iterations.
      start_op(DIVU, 32'h00001000, 32'h00000003, 32'h00000555, "div_abort");
      repeat (10) @(posedge clk);
      chk_en  = 1'b0;
      pending = 1'b0;
      @(negedge clk);
      I_rst = 1'b1;
      @(posedge clk);
      #1;
      chk1("abort_ready", O_ready, 1'b1);
      chk1("abort_valid", O_valid, 1'b0);
      chk1("abort_busy", O_busy, 1'b0);
      chk("abort_data", O_data, 32'd0);
      @(negedge clk);
      I_rst  = 1'b0;
      chk_en = 1'b1;
      repeat (40) @(posedge clk);
      op(ADD, 32'h00000002, 32'h00000003, 32'h00000005, "add_after_abort");

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
